// File: rtl/am_demod_pkg.sv
// Shared widths, constants, gain FSM states and output saturation for the AM demodulator chain.
package am_demod_pkg;

  localparam int DATA_W    = 14;
  localparam int AC_W      = 15;
  localparam int GAIN_W    = 12;
  localparam int GAIN_FRAC = 8;
  localparam int PROD_W    = AC_W + GAIN_W;

  localparam logic [DATA_W-1:0] MIDSCALE = 14'd8192;
  localparam logic [GAIN_W-1:0] GAIN_ONE = 12'd256;

  typedef enum logic [1:0] {IDLE, COUNT, UPDATE} gain_state_t;

  localparam logic signed [PROD_W-1:0] Y_MAX = 27'sd8191;
  localparam logic signed [PROD_W-1:0] Y_MIN = -27'sd8192;

  // Clamp a scaled product to the signed 14-bit audio range.
  function automatic logic signed [DATA_W-1:0] sat_audio(input logic signed [PROD_W-1:0] v);
    if (v > Y_MAX)
      return Y_MAX[DATA_W-1:0];
    else if (v < Y_MIN)
      return Y_MIN[DATA_W-1:0];
    else
      return v[DATA_W-1:0];
  endfunction

endpackage

// File: rtl/peak_tracker.sv
// Instant-attack, exponential-decay tracker of |ac|, updated once per valid sample.
module peak_tracker
  import am_demod_pkg::*;
#(
  parameter int DECAY_SHIFT = 10
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst,
  input  logic                   in_valid,
  input  logic signed [AC_W-1:0] ac,
  output logic [DATA_W-1:0]      peak
);

  logic [AC_W-1:0]   ac_abs;
  logic [DATA_W-1:0] mag;

  // Only -16384 produces a magnitude that needs bit 14; it saturates to 16383.
  always_comb begin
    ac_abs = ac[AC_W-1] ? $unsigned(-ac) : $unsigned(ac);
    mag    = ac_abs[AC_W-1] ? '1 : ac_abs[DATA_W-1:0];
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst)
      peak <= '0;
    else if (in_valid) begin
      if (mag > peak)
        peak <= mag;
      else
        peak <= peak - (peak >> DECAY_SHIFT);
    end
  end

endmodule

// File: rtl/am_envelope_agc.sv
// DC removal, frame-based AGC and 3-stage gain pipeline turning the FIR envelope into offset-binary DAC codes.
module am_envelope_agc
  import am_demod_pkg::*;
#(
  parameter int DC_SHIFT    = 12,
  parameter int FRAME_LEN   = 4096,
  parameter int DECAY_SHIFT = 10,
  parameter int TARGET      = 6000,
  parameter int HYST        = 400,
  parameter int GAIN_MIN    = 64,
  parameter int GAIN_MAX    = 4095
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] da_data,
  output logic [GAIN_W-1:0] gain,
  output logic [DATA_W-1:0] peak
);

  localparam int ACC_W = DATA_W + DC_SHIFT;
  localparam int CNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [ACC_W-1:0]  ACC_RESET = ACC_W'(MIDSCALE) << DC_SHIFT;
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(FRAME_LEN - 1);
  localparam logic [DATA_W-1:0] PEAK_HI   = DATA_W'(TARGET + HYST);
  localparam logic [DATA_W-1:0] PEAK_LO   = DATA_W'(TARGET - HYST);
  localparam logic [GAIN_W-1:0] G_MIN     = GAIN_W'(GAIN_MIN);
  localparam logic [GAIN_W-1:0] G_MAX     = GAIN_W'(GAIN_MAX);

  logic [ACC_W-1:0]           acc, acc_next;
  logic [DATA_W-1:0]          dc;
  logic signed [AC_W-1:0]     ac_now, ac_r;
  logic signed [PROD_W-1:0]   prod_full, prod_r, y_full;
  logic signed [DATA_W-1:0]   y_sat;
  logic                       v1, v2;
  gain_state_t                state, state_next;
  logic [CNT_W-1:0]           frame_cnt, cnt_next;
  logic [GAIN_W-1:0]          gain_next;

  always_comb begin
    dc        = acc[ACC_W-1:DC_SHIFT];
    ac_now    = $signed({1'b0, in_data}) - $signed({1'b0, dc});
    acc_next  = acc + ACC_W'(in_data) - ACC_W'(dc);
    prod_full = PROD_W'(ac_r) * PROD_W'($signed({1'b0, gain}));
    y_full    = prod_r >>> GAIN_FRAC;
    y_sat     = sat_audio(y_full);
  end

  // Data registers advance only with their stage's valid; the valid bits always shift so gaps drain out.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      acc       <= ACC_RESET;
      ac_r      <= '0;
      prod_r    <= '0;
      v1        <= 1'b0;
      v2        <= 1'b0;
      out_valid <= 1'b0;
      da_data   <= MIDSCALE;
    end else begin
      v1        <= in_valid;
      v2        <= v1;
      out_valid <= v2;
      if (in_valid) begin
        acc  <= acc_next;
        ac_r <= ac_now;
      end
      if (v1)
        prod_r <= prod_full;
      if (v2)
        da_data <= {~y_sat[DATA_W-1], y_sat[DATA_W-2:0]};
    end
  end

  peak_tracker #(
    .DECAY_SHIFT(DECAY_SHIFT)
  ) u_peak (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .in_valid(in_valid),
    .ac      (ac_now),
    .peak    (peak)
  );

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state     <= IDLE;
      frame_cnt <= '0;
      gain      <= GAIN_ONE;
    end else begin
      state     <= state_next;
      frame_cnt <= cnt_next;
      gain      <= gain_next;
    end
  end

  // A sample arriving in UPDATE is counted as the first of the next frame.
  always_comb begin
    state_next = state;
    cnt_next   = frame_cnt;
    gain_next  = gain;
    case (state)
      IDLE:   state_next = IDLE;
      COUNT:  state_next = COUNT;
      UPDATE: begin
        state_next = COUNT;
        if (peak > PEAK_HI)
          gain_next = (gain > G_MIN) ? gain - GAIN_W'(1) : G_MIN;
        else if (peak < PEAK_LO)
          gain_next = (gain < G_MAX) ? gain + GAIN_W'(1) : G_MAX;
      end
      default: state_next = IDLE;
    endcase
    if (in_valid) begin
      if (frame_cnt == CNT_LAST) begin
        cnt_next   = '0;
        state_next = UPDATE;
      end else begin
        cnt_next   = frame_cnt + CNT_W'(1);
        state_next = COUNT;
      end
    end
  end

endmodule

// File: tb/tb_am_envelope_agc.sv
// Scoreboard bench for am_envelope_agc: driver pushes expected DAC codes, a monitor pops them on out_valid.
module tb_am_envelope_agc;

  localparam int DC_SHIFT    = 6;
  localparam int FRAME_LEN   = 64;
  localparam int DECAY_SHIFT = 4;
  localparam int TARGET      = 6000;
  localparam int HYST        = 400;
  localparam int GAIN_MIN    = 250;
  localparam int GAIN_MAX    = 270;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        in_valid;
  logic [13:0] in_data;
  logic        out_valid;
  logic [13:0] da_data;
  logic [11:0] gain;
  logic [13:0] peak;

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;

  typedef struct {
    int data;
    int cyc;
  } exp_t;
  exp_t sb[$];

  longint m_acc;
  int     m_peak, m_gain, m_cnt;

  am_envelope_agc #(
    .DC_SHIFT(DC_SHIFT), .FRAME_LEN(FRAME_LEN), .DECAY_SHIFT(DECAY_SHIFT),
    .TARGET(TARGET), .HYST(HYST), .GAIN_MIN(GAIN_MIN), .GAIN_MAX(GAIN_MAX)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .in_valid (in_valid),
    .in_data  (in_data),
    .out_valid(out_valid),
    .da_data  (da_data),
    .gain     (gain),
    .peak     (peak)
  );

  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    tests_run++;
    if (actual != expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic checkOutputRange(input string name, input int actual, input int lo, input int hi);
    tests_run++;
    if (actual < lo || actual > hi) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d..%0d", name, actual, lo, hi);
    end
  endtask

  function automatic void modelReset();
    m_acc  = 64'(8192) * (64'(1) << DC_SHIFT);
    m_peak = 0;
    m_gain = 256;
    m_cnt  = 0;
  endfunction

  // Sample-level reference: DC leak, gain/scale/saturate, peak tracking, frame-end gain step.
  function automatic int modelStep(input int x);
    int     dc, ac, mag, y;
    longint p;
    dc    = int'(m_acc / (64'(1) << DC_SHIFT));
    ac    = x - dc;
    m_acc = m_acc + x - dc;
    mag   = (ac < 0) ? -ac : ac;
    if (mag > 16383) mag = 16383;
    p = longint'(ac) * m_gain;
    y = (p >= 0) ? int'(p / 256) : -int'((-p + 255) / 256);
    if (y > 8191) y = 8191;
    if (y < -8192) y = -8192;
    if (mag > m_peak) m_peak = mag;
    else m_peak = m_peak - m_peak / (1 << DECAY_SHIFT);
    m_cnt++;
    if (m_cnt == FRAME_LEN) begin
      m_cnt = 0;
      if (m_peak > TARGET + HYST) m_gain = (m_gain > GAIN_MIN) ? m_gain - 1 : GAIN_MIN;
      else if (m_peak < TARGET - HYST) m_gain = (m_gain < GAIN_MAX) ? m_gain + 1 : GAIN_MAX;
    end
    return y + 8192;
  endfunction

  // hand >= 0 overrides the model with a hand-computed expected code.
  task automatic applyStimulus(input logic [13:0] x, input int hand);
    int   m;
    exp_t e;
    @(posedge sys_clk);
    #1;
    in_valid = 1'b1;
    in_data  = x;
    m        = modelStep(int'(x));
    e.data   = (hand >= 0) ? hand : m;
    e.cyc    = cyc + 3;
    sb.push_back(e);
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge sys_clk);
      #1;
      in_valid = 1'b0;
    end
  endtask

  always @(negedge sys_clk) begin
    exp_t e;
    if (!sys_rst && out_valid) begin
      if (sb.size() == 0)
        checkOutput("unexpected out_valid", 1, 0);
      else begin
        e = sb.pop_front();
        checkOutput("da_data", int'(da_data), e.data);
        checkOutput("out_valid cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    #10000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    sys_rst  = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    modelReset();
    repeat (3) @(posedge sys_clk);
    #1;
    checkOutput("reset da_data", int'(da_data), 8192);
    checkOutput("reset out_valid", int'(out_valid), 0);
    checkOutput("reset gain", int'(gain), 256);
    checkOutput("reset peak", int'(peak), 0);
    sys_rst = 1'b0;

    applyStimulus(14'd8192, 8192);
    applyStimulus(14'd9192, 9192);
    applyStimulus(14'd8192, 8177);
    idleCycles(4);
    checkOutput("peak after decay", int'(peak), 938);
    checkOutput("gain before first frame", int'(gain), 256);

    for (int i = 0; i < 512; i++) applyStimulus(14'd10000, -1);
    idleCycles(4);
    checkOutputRange("settled da_data", int'(da_data), 8191, 8193);
    checkOutput("gain after quiet frames", int'(gain), 264);

    for (int i = 0; i < 256; i++)
      applyStimulus(((i / 32) % 2 == 0) ? 14'd9192 : 14'd7192, -1);
    idleCycles(2);
    checkOutput("gain climbing", int'(gain), 268);
    for (int i = 256; i < 512; i++)
      applyStimulus(((i / 32) % 2 == 0) ? 14'd9192 : 14'd7192, -1);
    idleCycles(2);
    checkOutput("gain capped at max", int'(gain), 270);
    checkOutput("peak small square", int'(peak), m_peak);
    checkOutputRange("peak small square range", int'(peak), 1, 5599);

    for (int i = 0; i < 1920; i++)
      applyStimulus(((i / 8) % 2 == 0) ? 14'd16192 : 14'd192, -1);
    idleCycles(2);
    checkOutput("gain floored at min", int'(gain), 250);
    checkOutputRange("peak large square", int'(peak), 6401, 16383);

    for (int i = 0; i < 512; i++) applyStimulus(14'd0, -1);
    applyStimulus(14'd16383, 16383);
    for (int i = 0; i < 511; i++) applyStimulus(14'd16383, -1);
    applyStimulus(14'd0, 0);
    idleCycles(4);
    checkOutputRange("peak full-scale step", int'(peak), 16000, 16383);

    for (int i = 0; i < 192; i++) begin
      applyStimulus(((i / 4) % 2 == 0) ? 14'd8692 : 14'd7692, -1);
      idleCycles(2);
    end
    idleCycles(5);
    checkOutput("gain with gapped input", int'(gain), m_gain);
    checkOutput("scoreboard drained", sb.size(), 0);

    applyStimulus(14'd9000, -1);
    applyStimulus(14'd9100, -1);
    applyStimulus(14'd9200, -1);
    @(posedge sys_clk);
    #3;
    sys_rst  = 1'b1;
    in_valid = 1'b0;
    sb.delete();
    modelReset();
    #1;
    checkOutput("mid-frame reset da_data", int'(da_data), 8192);
    checkOutput("mid-frame reset out_valid", int'(out_valid), 0);
    checkOutput("mid-frame reset gain", int'(gain), 256);
    checkOutput("mid-frame reset peak", int'(peak), 0);
    repeat (2) @(posedge sys_clk);
    #2;
    sys_rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge sys_clk);
      checkOutput("no stale out_valid", int'(out_valid), 0);
    end
    checkOutput("gain after reset release", int'(gain), 256);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
